// File: rtl/proc_pkg.sv
// Shared opcode, ALU-op, destination-select and state encodings for the sequencing controller.
package proc_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_RSV5 = 3'd5;
  localparam logic [2:0] OP_RSV6 = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [2:0] ADDSUB_ADD = 3'b000;
  localparam logic [2:0] ADDSUB_SUB = 3'b001;

  localparam logic [1:0] DEST_IN   = 2'd0;
  localparam logic [1:0] DEST_REGY = 2'd1;
  localparam logic [1:0] DEST_ALU  = 2'd2;
  localparam logic [1:0] DEST_REGX = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WAIT_IN  = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

endpackage

// File: rtl/proc_decoder.sv
// Combinational opcode decode: datapath controls plus instruction-class flags.
module proc_decoder
  import proc_pkg::*;
#(
  parameter int ADDSUB_W = 3
) (
  input  logic [2:0]          opcode_i,
  output logic [1:0]          dest_src_o,
  output logic [ADDSUB_W-1:0] addsub_o,
  output logic                writes_o,
  output logic                is_load_o,
  output logic                is_out_o,
  output logic                is_halt_o,
  output logic                illegal_o
);

  always_comb begin
    dest_src_o = DEST_IN;
    addsub_o   = ADDSUB_W'(ADDSUB_ADD);
    writes_o   = 1'b0;
    is_load_o  = 1'b0;
    is_out_o   = 1'b0;
    is_halt_o  = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_LOAD: is_load_o = 1'b1;
      OP_MOV: begin
        dest_src_o = DEST_REGY;
        writes_o   = 1'b1;
      end
      OP_ADD: begin
        dest_src_o = DEST_ALU;
        writes_o   = 1'b1;
      end
      OP_SUB: begin
        dest_src_o = DEST_ALU;
        addsub_o   = ADDSUB_W'(ADDSUB_SUB);
        writes_o   = 1'b1;
      end
      OP_OUT: begin
        dest_src_o = DEST_REGX;
        is_out_o   = 1'b1;
      end
      OP_RSV5, OP_RSV6: illegal_o = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_controller.sv
// Fetch/decode/execute sequencer for the 8-bit datapath with valid/ready operand and result handshakes.
// Optional retired-instruction counter is enabled by defining INSTR_COUNT_EN.
module proc_controller
  import proc_pkg::*;
#(
  parameter int ADDSUB_W = 3
`ifdef INSTR_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [8:0]          instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          Rx,
  output logic [2:0]          Ry,
  output logic [ADDSUB_W-1:0] addsub,
  output logic [1:0]          destSrc,
  output logic                regWrite,
  output logic                busy,
  output logic                halted,
  output logic                illegal
`ifdef INSTR_COUNT_EN
  , output logic [CNT_W-1:0]  instr_count
`endif
);

  state_t              state_q, state_d;
  logic [8:0]          ir_q, ir_d;
  logic                illegal_q, illegal_d;

  logic [1:0]          dec_dest;
  logic [ADDSUB_W-1:0] dec_addsub;
  logic                dec_writes, dec_is_load, dec_is_out, dec_is_halt, dec_illegal;

  proc_decoder #(.ADDSUB_W(ADDSUB_W)) u_dec (
    .opcode_i   (ir_q[8:6]),
    .dest_src_o (dec_dest),
    .addsub_o   (dec_addsub),
    .writes_o   (dec_writes),
    .is_load_o  (dec_is_load),
    .is_out_o   (dec_is_out),
    .is_halt_o  (dec_is_halt),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_FETCH;
          illegal_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_illegal) illegal_d = 1'b1;
        if (dec_is_load)      state_d = ST_WAIT_IN;
        else if (dec_is_out)  state_d = ST_WAIT_OUT;
        else if (dec_is_halt) state_d = ST_HALT;
        else                  state_d = ST_FETCH;
      end
      ST_WAIT_IN:  if (data_valid) state_d = ST_FETCH;
      ST_WAIT_OUT: if (out_ready)  state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Controls decode from registered state; only the LOAD write strobe follows data_valid directly.
  assign Rx          = ir_q[5:3];
  assign Ry          = ir_q[2:0];
  assign instr_ready = (state_q == ST_FETCH);
  assign data_ready  = (state_q == ST_WAIT_IN);
  assign out_valid   = (state_q == ST_WAIT_OUT);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted      = (state_q == ST_HALT);
  assign illegal     = illegal_q;
  assign regWrite    = ((state_q == ST_EXEC) && dec_writes) ||
                       ((state_q == ST_WAIT_IN) && data_valid);
  assign addsub      = (state_q == ST_EXEC) ? dec_addsub : '0;
  assign destSrc     = (state_q == ST_EXEC)     ? dec_dest  :
                       (state_q == ST_WAIT_OUT) ? DEST_REGX : DEST_IN;

`ifdef INSTR_COUNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign retire = ((state_q == ST_EXEC) && !dec_is_load && !dec_is_out) ||
                  ((state_q == ST_WAIT_IN) && data_valid) ||
                  ((state_q == ST_WAIT_OUT) && out_ready);
  assign cnt_d  = cnt_q + CNT_W'(retire);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule
